// File: rtl/pwm_cfg_shadow_bank.sv
// PWM config shadow bank: per-channel live word loaded only at safe points.
// Ports: mclk, h_reset_n, enb/cfg_update/cfg_dupdate/upd_mode/period_end,
//   reg_in -> reg_out (NCH*WD packed), upd_pend, upd_done.
module pwm_cfg_shadow_bank #(
  parameter int NCH = 4,
  parameter int WD  = 32
) (
  input  logic              mclk,
  input  logic              h_reset_n,
  input  logic [NCH-1:0]    enb,
  input  logic [NCH-1:0]    cfg_update,
  input  logic [NCH-1:0]    cfg_dupdate,
  input  logic [NCH-1:0]    upd_mode,
  input  logic [NCH-1:0]    period_end,
  input  logic [NCH*WD-1:0] reg_in,
  output logic [NCH*WD-1:0] reg_out,
  output logic [NCH-1:0]    upd_pend,
  output logic [NCH-1:0]    upd_done
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } st_t;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    st_t           st_q, st_d;
    logic [WD-1:0] out_q, out_d;
    logic [WD-1:0] stg_q, stg_d;
    logic          done_d;
    logic [WD-1:0] din;
    logic          pend;

    assign din  = reg_in[c*WD +: WD];
    assign pend = (st_q == PEND);

    always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
        st_q        <= IDLE;
        out_q       <= '0;
        stg_q       <= '0;
        upd_done[c] <= 1'b0;
      end else begin
        st_q        <= st_d;
        out_q       <= out_d;
        stg_q       <= stg_d;
        upd_done[c] <= done_d;
      end
    end

    // Lock beats disable beats enabled-mode handling.
    always_comb begin
      st_d   = st_q;
      out_d  = out_q;
      stg_d  = stg_q;
      done_d = 1'b0;
      if (cfg_dupdate[c]) begin
        if (cfg_update[c]) begin
          stg_d = din;
          st_d  = PEND;
        end
      end else if (!enb[c]) begin
        out_d = din;
        st_d  = IDLE;
      end else if (!upd_mode[c]) begin
        if (cfg_update[c]) begin
          out_d  = din;
          st_d   = IDLE;
          done_d = 1'b1;
        end else if (pend) begin
          // request recorded under lock or before a mode switch
          out_d  = stg_q;
          st_d   = IDLE;
          done_d = 1'b1;
        end
      end else begin
        if (cfg_update[c] && period_end[c]) begin
          out_d  = din;
          st_d   = IDLE;
          done_d = 1'b1;
        end else if (cfg_update[c]) begin
          stg_d = din;
          st_d  = PEND;
        end else if (period_end[c] && pend) begin
          out_d  = stg_q;
          st_d   = IDLE;
          done_d = 1'b1;
        end
      end
    end

    assign reg_out[c*WD +: WD] = out_q;
    assign upd_pend[c]         = pend;
  end

endmodule

// File: tb/tb_pwm_cfg_shadow_bank.sv
// Directed bench for pwm_cfg_shadow_bank (NCH=4, WD=32).
// Hand-computed expectations checked through one compare task.
module tb_pwm_cfg_shadow_bank;

  logic         mclk = 1'b0;
  logic         h_reset_n = 1'b0;
  logic [3:0]   enb = '0;
  logic [3:0]   cfg_update = '0;
  logic [3:0]   cfg_dupdate = '0;
  logic [3:0]   upd_mode = '0;
  logic [3:0]   period_end = '0;
  logic [127:0] reg_in = '0;
  logic [127:0] reg_out;
  logic [3:0]   upd_pend;
  logic [3:0]   upd_done;

  int n_vec = 0;
  int n_err = 0;

  pwm_cfg_shadow_bank #(.NCH(4), .WD(32)) dut (
    .mclk        (mclk),
    .h_reset_n   (h_reset_n),
    .enb         (enb),
    .cfg_update  (cfg_update),
    .cfg_dupdate (cfg_dupdate),
    .upd_mode    (upd_mode),
    .period_end  (period_end),
    .reg_in      (reg_in),
    .reg_out     (reg_out),
    .upd_pend    (upd_pend),
    .upd_done    (upd_done)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  function automatic logic [31:0] ch(input int c);
    return reg_out[c*32 +: 32];
  endfunction

  initial begin
    #2;
    chk("rst_out", reg_out, '0);
    chk("rst_pend", {124'd0, upd_pend}, '0);
    chk("rst_done", {124'd0, upd_done}, '0);
    #20;
    h_reset_n = 1'b1;

    // disabled follow
    reg_in[31:0] = 32'h1234;
    tick();
    chk("follow_out", {96'd0, ch(0)}, 128'h1234);
    chk("follow_done", {124'd0, upd_done}, '0);
    chk("follow_pend", {124'd0, upd_pend}, '0);

    // immediate
    enb[0] = 1'b1;
    reg_in[31:0] = 32'hAAAA;
    cfg_update[0] = 1'b1;
    tick();
    cfg_update[0] = 1'b0;
    reg_in[31:0] = 32'hBBBB;
    chk("imm_out", {96'd0, ch(0)}, 128'hAAAA);
    chk("imm_done", {124'd0, upd_done}, 128'h1);
    tick();
    chk("imm_hold", {96'd0, ch(0)}, 128'hAAAA);
    chk("imm_done0", {124'd0, upd_done}, '0);

    // deferred with staging
    upd_mode[0] = 1'b1;
    reg_in[31:0] = 32'h0055;
    cfg_update[0] = 1'b1;
    tick();
    cfg_update[0] = 1'b0;
    reg_in[31:0] = 32'h9999;
    chk("def_pend", {124'd0, upd_pend}, 128'h1);
    chk("def_hold", {96'd0, ch(0)}, 128'hAAAA);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("def_wait", {124'd0, upd_pend, upd_done}, 128'h10);
    end
    period_end[0] = 1'b1;
    tick();
    period_end[0] = 1'b0;
    chk("def_out", {96'd0, ch(0)}, 128'h0055);
    chk("def_done", {124'd0, upd_pend, upd_done}, 128'h01);
    tick();
    chk("def_done0", {124'd0, upd_done}, '0);

    // repeat request overwrites stage
    cfg_update[0] = 1'b1;
    reg_in[31:0] = 32'h11;
    tick();
    reg_in[31:0] = 32'h22;
    tick();
    cfg_update[0] = 1'b0;
    chk("rep_pend", {124'd0, upd_pend, upd_done}, 128'h10);
    period_end[0] = 1'b1;
    tick();
    period_end[0] = 1'b0;
    chk("rep_out", {96'd0, ch(0)}, 128'h22);
    chk("rep_done", {124'd0, upd_pend, upd_done}, 128'h01);
    tick();
    chk("rep_done0", {124'd0, upd_done}, '0);

    // coincident request and period_end
    cfg_update[0] = 1'b1;
    period_end[0] = 1'b1;
    reg_in[31:0] = 32'h33;
    tick();
    cfg_update[0] = 1'b0;
    period_end[0] = 1'b0;
    chk("coin_out", {96'd0, ch(0)}, 128'h33);
    chk("coin_st", {124'd0, upd_pend, upd_done}, 128'h01);

    // lock
    cfg_dupdate[0] = 1'b1;
    cfg_update[0] = 1'b1;
    period_end[0] = 1'b1;
    reg_in[31:0] = 32'h77;
    tick();
    cfg_update[0] = 1'b0;
    reg_in[31:0] = 32'h5;
    chk("lock_out", {96'd0, ch(0)}, 128'h33);
    chk("lock_st", {124'd0, upd_pend, upd_done}, 128'h10);
    tick();
    period_end[0] = 1'b0;
    chk("lock_pe", {96'd0, ch(0)}, 128'h33);
    cfg_dupdate[0] = 1'b0;
    upd_mode[0] = 1'b0;
    tick();
    chk("unlock_out", {96'd0, ch(0)}, 128'h77);
    chk("unlock_st", {124'd0, upd_pend, upd_done}, 128'h01);

    // all channels at once
    enb = 4'b1011;
    upd_mode = 4'b0010;
    cfg_dupdate = 4'b1000;
    cfg_update = 4'b1011;
    reg_in = {32'h303, 32'h202, 32'h101, 32'h404};
    tick();
    cfg_update = '0;
    chk("mc_out", reg_out, {32'h0, 32'h202, 32'h0, 32'h404});
    chk("mc_st", {124'd0, upd_pend, upd_done}, 128'hA1);
    reg_in[95:64] = 32'h2F2;
    tick();
    chk("mc_out2", reg_out, {32'h0, 32'h2F2, 32'h0, 32'h404});
    chk("mc_st2", {124'd0, upd_pend, upd_done}, 128'hA0);

    // disable while pending
    enb[1] = 1'b0;
    tick();
    chk("dis_out", {96'd0, ch(1)}, 128'h101);
    chk("dis_st", {124'd0, upd_pend, upd_done}, 128'h80);

    // async reset mid-pend
    #3;
    h_reset_n = 1'b0;
    #1;
    chk("ar_out", reg_out, '0);
    chk("ar_st", {124'd0, upd_pend, upd_done}, '0);
    #2;
    h_reset_n = 1'b1;
    tick();
    chk("ar_post", {124'd0, upd_pend, upd_done}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
